// File: rtl/xor_gate_pkg.sv
// Shared constants for the registered XOR/XNOR pair.
package xor_gate_pkg;

  localparam int XOR_DEFAULT_WIDTH = 1;

  // Per-bit reset values; replicated to the instance width where used.
  localparam logic XOR_RST_C = 1'b0;
  localparam logic XOR_RST_D = 1'b1;

endpackage

// File: rtl/xor_out_reg.sv
// WIDTH-wide flop bank with asynchronous active-high reset to a per-instance value.
module xor_out_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Capture on each rising edge; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/xor_gate_pair.sv
// Bitwise XOR and XNOR of two operands, optionally registered for one-cycle latency.
module xor_gate_pair
  import xor_gate_pkg::*;
#(
  parameter int WIDTH   = XOR_DEFAULT_WIDTH,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D
);

  logic [WIDTH-1:0] xor_d;
  logic [WIDTH-1:0] xnor_d;

  assign xor_d  = A ^ B;
  assign xnor_d = ~(A ^ B);

  generate
    if (REG_OUT) begin : g_reg
      // Both banks share rst so D == ~C holds even while reset is asserted.
      xor_out_reg #(
        .WIDTH  (WIDTH),
        .RST_VAL({WIDTH{XOR_RST_C}})
      ) u_c_reg (
        .clk(clk),
        .rst(rst),
        .d_i(xor_d),
        .q_o(C)
      );

      xor_out_reg #(
        .WIDTH  (WIDTH),
        .RST_VAL({WIDTH{XOR_RST_D}})
      ) u_d_reg (
        .clk(clk),
        .rst(rst),
        .d_i(xnor_d),
        .q_o(D)
      );
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign C = xor_d;
      assign D = xnor_d;
    end
  endgenerate

endmodule

// File: tb/tb_xor_gate_pair.sv
// Scoreboard bench: registered 1-bit instance and combinational 8-bit bypass instance.
module tb_xor_gate_pair;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] an, bn, cn, dn;
  logic [7:0] aw, bw, cw, dw;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] c;
    logic [7:0] d;
    bit         wide;
  } exp_t;

  exp_t clk_q[$];
  exp_t imm_q[$];
  event imm_ev;

  always #5 clk = ~clk;

  xor_gate_pair #(.WIDTH(1), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst(rst), .A(an), .B(bn), .C(cn), .D(dn)
  );

  xor_gate_pair #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .A(aw), .B(bw), .C(cw), .D(dw)
  );

  task automatic check(input exp_t e);
    logic [7:0] ac, ad, mask;
    if (e.wide) begin
      ac = cw; ad = dw; mask = 8'hFF;
    end else begin
      ac = {7'b0, cn}; ad = {7'b0, dn}; mask = 8'h01;
    end
    checks++;
    if (ac !== e.c || ad !== e.d) begin
      errors++;
      $display("FAIL %s: got C=%h D=%h, expected C=%h D=%h", e.name, ac, ad, e.c, e.d);
    end
    checks++;
    if ((ad & mask) !== (~ac & mask)) begin
      errors++;
      $display("FAIL %s_inv: got C=%h D=%h, expected D == ~C", e.name, ac, ad);
    end
  endtask

  // Clocked monitor: one expectation per falling edge, i.e. one rising edge after it was pushed.
  initial begin
    forever begin
      @(negedge clk);
      if (clk_q.size() > 0) check(clk_q.pop_front());
    end
  end

  // Immediate monitor: samples shortly after the stimulus asks, no clock edge in between.
  initial begin
    forever begin
      @(imm_ev);
      #1;
      while (imm_q.size() > 0) check(imm_q.pop_front());
    end
  end

  task automatic push_clk(input string name, input logic [7:0] c, input logic [7:0] d);
    exp_t e;
    e.name = name; e.c = c; e.d = d; e.wide = 1'b0;
    clk_q.push_back(e);
  endtask

  task automatic imm(input string name, input logic [7:0] c, input logic [7:0] d, input bit wide);
    exp_t e;
    e.name = name; e.c = c; e.d = d; e.wide = wide;
    imm_q.push_back(e);
    ->imm_ev;
    #2;
  endtask

  task automatic next_slot();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; an = 1'b1; bn = 1'b0; aw = 8'h00; bw = 8'h00;
    #1;
    imm("rst_no_edge", 8'h00, 8'h01, 1'b0);
    repeat (3) begin
      next_slot();
      push_clk("rst_hold", 8'h00, 8'h01);
    end

    next_slot(); rst = 1'b0; an = 1'b0; bn = 1'b0; push_clk("tt_00", 8'h00, 8'h01);
    next_slot(); an = 1'b1; bn = 1'b0; push_clk("tt_10", 8'h01, 8'h00);
    next_slot(); an = 1'b0; bn = 1'b1; push_clk("tt_01", 8'h01, 8'h00);
    next_slot(); an = 1'b1; bn = 1'b1; push_clk("tt_11", 8'h00, 8'h01);
    repeat (5) begin
      next_slot();
      push_clk("tt_11_hold", 8'h00, 8'h01);
    end

    next_slot(); an = 1'b0; bn = 1'b0; push_clk("lat_base", 8'h00, 8'h01);
    next_slot(); an = 1'b1;
    imm("lat_before_edge", 8'h00, 8'h01, 1'b0);
    push_clk("lat_after_edge", 8'h01, 8'h00);

    next_slot(); rst = 1'b1;
    imm("async_rst", 8'h00, 8'h01, 1'b0);
    rst = 1'b0;
    push_clk("rst_release", 8'h01, 8'h00);

    next_slot();
    aw = 8'hA5; bw = 8'h0F; imm("wide_a5_0f", 8'hAA, 8'h55, 1'b1);
    aw = 8'h00; bw = 8'h00; imm("wide_00_00", 8'h00, 8'hFF, 1'b1);
    aw = 8'hFF; bw = 8'h00; imm("wide_ff_00", 8'hFF, 8'h00, 1'b1);
    aw = 8'h3C; bw = 8'hC3; imm("wide_3c_c3", 8'hFF, 8'h00, 1'b1);
    aw = 8'hFF; bw = 8'hFF; imm("wide_ff_ff", 8'h00, 8'hFF, 1'b1);
    aw = 8'h96; bw = 8'h5A; imm("wide_96_5a", 8'hCC, 8'h33, 1'b1);

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (clk_q.size() != 0 || imm_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", clk_q.size(), imm_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
